// File: rtl/q2_seq_pkg.sv
// Shared definitions for the Q2 machine-state sequencer: state encodings,
// opcode field width and the shift-class opcode decode.
package q2_seq_pkg;

  localparam int OP_W  = 3;
  localparam int CNT_W = 3;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'b0000,
    ST_DEREF    = 4'b0001,
    ST_LOAD     = 4'b0010,
    ST_EXEC     = 4'b0011,
    ST_ALU      = 4'b0100,
    ST_ALU_LAST = 4'b1000
  } state_e;

  // Shift-class instructions (o2=0 with a nonzero low field) run the bit-serial ALU.
  function automatic logic is_shift_op(input logic [OP_W-1:0] op);
    return ~op[2] & (op[1] | op[0]);
  endfunction

endpackage

// File: rtl/q2_step_edge.sv
// Registered rising-edge detector for the single-step button; one-clock pulse per press.
module q2_step_edge (
  input  logic clk,
  input  logic rst,
  input  logic step,
  output logic pulse
);

  logic step_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_q <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      step_q <= step;
      pulse  <= step & ~step_q;
    end
  end

endmodule

// File: rtl/q2_state_sequencer.sv
// Q2 CPU machine-state generator: two-clock states (read then write phase).
// Optional single-step control is enabled with the Q2_SINGLE_STEP_EN macro.
module q2_state_sequencer
  import q2_seq_pkg::*;
#(
  parameter int ALU_STEPS = 8,
  parameter int OP_MSB    = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic [7:0]      dbus,
`ifdef Q2_SINGLE_STEP_EN
  input  logic            step,
`endif
  output logic [3:0]      s,
  output logic [3:0]      ns,
  output logic            ws,
  output logic [OP_W-1:0] o,
  output logic [OP_W-1:0] no,
  output logic            deref,
  output logic            halted
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ALU_STEPS - 2);

  state_e            state_q, state_d;
  logic              ws_q, ws_d;
  logic [OP_W-1:0]   o_q, o_d;
  logic              deref_q, deref_d;
  logic              halted_q, halted_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        ns_q;
  logic [OP_W-1:0]   no_q;

  logic [OP_W-1:0]   fetch_op;
  logic              fetch_deref;

  assign fetch_op    = dbus[OP_MSB -: OP_W];
  assign fetch_deref = dbus[OP_MSB-3];

`ifdef Q2_SINGLE_STEP_EN
  logic step_pulse;

  q2_step_edge u_step_edge (
    .clk   (clk),
    .rst   (rst),
    .step  (step),
    .pulse (step_pulse)
  );
`endif

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    ws_d     = ws_q;
    o_d      = o_q;
    deref_d  = deref_q;
    halted_d = halted_q;
    cnt_d    = cnt_q;

    if (!ws_q) begin
      // Read phase: either park (halted) or move on to the write phase.
      if (halted_q) begin
        if (run) begin
          ws_d     = 1'b1;
          halted_d = 1'b0;
        end
`ifdef Q2_SINGLE_STEP_EN
        else if (step_pulse) begin
          ws_d = 1'b1;
        end
`endif
      end else if (state_q == ST_FETCH && !run) begin
        halted_d = 1'b1;
      end else begin
        ws_d = 1'b1;
      end
    end else begin
      ws_d = 1'b0;
      unique case (state_q)
        ST_FETCH: begin
          o_d     = fetch_op;
          deref_d = fetch_deref;
          if (fetch_deref)       state_d = ST_DEREF;
          else if (!fetch_op[2]) state_d = ST_LOAD;
          else                   state_d = ST_EXEC;
        end
        ST_DEREF:    state_d = o_q[2] ? ST_EXEC : ST_LOAD;
        ST_LOAD:     state_d = ST_EXEC;
        ST_EXEC:     state_d = is_shift_op(o_q) ? ST_ALU : ST_FETCH;
        ST_ALU: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) state_d = ST_ALU_LAST;
        end
        ST_ALU_LAST: begin
          cnt_d   = '0;
          state_d = ST_FETCH;
        end
        default: begin
          cnt_d   = '0;
          state_d = ST_FETCH;
        end
      endcase
      // A stepped advance stays halted; a free-running one halts only on reaching FETCH.
      halted_d = halted_q ? !run : (state_d == ST_FETCH && !run);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FETCH;
      ws_q     <= 1'b0;
      o_q      <= '0;
      deref_q  <= 1'b0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
      ns_q     <= 4'b1111;
      no_q     <= '1;
    end else begin
      state_q  <= state_d;
      ws_q     <= ws_d;
      o_q      <= o_d;
      deref_q  <= deref_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
      ns_q     <= ~state_d;
      no_q     <= ~o_d;
    end
  end

  assign s      = state_q;
  assign ns     = ns_q;
  assign ws     = ws_q;
  assign o      = o_q;
  assign no     = no_q;
  assign deref  = deref_q;
  assign halted = halted_q;

endmodule
